// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   16x-oversampled 8N1 UART receiver feeding a first-word-fall-through FIFO.
//   The FIFO handshake and status outputs match the transmitter-side buffer.
//
// Parameters
//   FIFO_AW             FIFO address width, depth = 2**FIFO_AW words (>= 2)
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous active-low reset
//   en_16_x_baud        one-cycle tick at 16x the baud rate (may be tied 1)
//   rx                  asynchronous serial input, idle high
//   buffer_read         pop the head word (ignored when empty)
//   buffer_reset        synchronous FIFO clear, receiver FSM unaffected
//   data_out            FIFO head word, 0x00 when empty
//   buffer_data_present FIFO not empty
//   buffer_half_full    count >= depth/2
//   buffer_full         count == depth
//   frame_error         one-cycle pulse, stop bit sampled low
//   overrun             one-cycle pulse, good byte dropped on a full FIFO
//   parity_error        one-cycle pulse, even-parity mismatch
// Build option
//   UART_RX_PARITY_EN   adds an even-parity bit between data and stop;
//                       when undefined the frame is 8N1 and parity_error is 0
module uart_rx_fifo #(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_16_x_baud,
    input  logic       rx,
    input  logic       buffer_read,
    input  logic       buffer_reset,
    output logic [7:0] data_out,
    output logic       buffer_data_present,
    output logic       buffer_half_full,
    output logic       buffer_full,
    output logic       frame_error,
    output logic       overrun,
    output logic       parity_error
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    localparam logic [FIFO_AW:0]   DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   HALF_C  = {2'b01, {(FIFO_AW-1){1'b0}}};
    localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic       rx_meta, rx_s, rx_s_d;
    logic       fall;
    logic [3:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       start_ok, data_smp, stop_smp;
    logic       par_bad, byte_good, overrun_set;

    logic [7:0]         mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count, count_nxt;
    logic               do_read, do_write;

    // Two-flop synchroniser plus one more stage for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // A line held low never produces a new edge, so a break cannot retrigger
    assign fall = rx_s_d & ~rx_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fall) state_nxt = S_START;
            S_START: if (en_16_x_baud && cnt == 4'd7)
                         state_nxt = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (en_16_x_baud && cnt == 4'd15 && bit_idx == 3'd7)
                          state_nxt = S_PARITY;
            S_PARITY: if (en_16_x_baud && cnt == 4'd15) state_nxt = S_STOP;
`else
            S_DATA:   if (en_16_x_baud && cnt == 4'd15 && bit_idx == 3'd7)
                          state_nxt = S_STOP;
`endif
            S_STOP:  if (en_16_x_baud && cnt == 4'd15) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_smp, par_bit;
`endif

    always_comb begin
        start_ok = 1'b0;
        data_smp = 1'b0;
        stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp  = 1'b0;
`endif
        case (state)
            S_START:  start_ok = en_16_x_baud && cnt == 4'd7 && !rx_s;
            S_DATA:   data_smp = en_16_x_baud && cnt == 4'd15;
`ifdef UART_RX_PARITY_EN
            S_PARITY: par_smp  = en_16_x_baud && cnt == 4'd15;
`endif
            S_STOP:   stop_smp = en_16_x_baud && cnt == 4'd15;
            default:  ;
        endcase
    end

    // Counter free-runs modulo 16 on ticks; it is only re-zeroed at the
    // detected start edge and at the mid-start-bit sample, which aligns all
    // later samples to mid-bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if ((state == S_IDLE && fall) || start_ok) cnt <= '0;
            else if (en_16_x_baud)                     cnt <= cnt + 4'd1;
            if (start_ok)      bit_idx <= '0;
            else if (data_smp) bit_idx <= bit_idx + 3'd1;
            if (data_smp) shreg <= {rx_s, shreg[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       par_bit <= 1'b0;
        else if (par_smp) par_bit <= rx_s;
    end
    assign par_bad = ^{shreg, par_bit};
`else
    assign par_bad = 1'b0;
`endif

    assign byte_good   = stop_smp & rx_s & ~par_bad;
    assign do_read     = buffer_read && (count != '0) && !buffer_reset;
    assign do_write    = byte_good && !buffer_reset && (count != DEPTH_C || do_read);
    assign overrun_set = byte_good && (count == DEPTH_C) && !buffer_read;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= stop_smp & ~rx_s;
            overrun     <= overrun_set;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parity_error <= 1'b0;
        else        parity_error <= stop_smp & rx_s & par_bad;
    end
`else
    assign parity_error = 1'b0;
`endif

    always_comb begin
        count_nxt = count;
        if (buffer_reset)             count_nxt = '0;
        else if (do_write && !do_read) count_nxt = count + CNT_ONE;
        else if (do_read && !do_write) count_nxt = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            buffer_data_present <= 1'b0;
            buffer_half_full    <= 1'b0;
            buffer_full         <= 1'b0;
        end else begin
            if (buffer_reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
                if (do_read)  rd_ptr <= rd_ptr + PTR_ONE;
            end
            count               <= count_nxt;
            buffer_data_present <= (count_nxt != '0);
            buffer_half_full    <= (count_nxt >= HALF_C);
            buffer_full         <= (count_nxt == DEPTH_C);
        end
    end

    assign data_out = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo. A queue-based model of the FIFO
//   contents and expected pulse counts is updated per frame; the DUT's
//   flags, head word and observed pulses are compared against it.
//   Honours UART_RX_PARITY_EN to add the parity bit to each frame.
module tb_uart_rx_fifo;

`ifdef UART_RX_PARITY_EN
    localparam int  NB  = 11;
    localparam bit  PAR = 1'b1;
`else
    localparam int  NB  = 10;
    localparam bit  PAR = 1'b0;
`endif
    // Loop iteration whose following edge is the stop-sample edge (div = 1)
    localparam int STOP_C = PAR ? 170 : 154;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en_16_x_baud = 1'b1;
    logic       rx = 1'b1;
    logic       buffer_read = 1'b0;
    logic       buffer_reset = 1'b0;
    logic [7:0] data_out;
    logic       buffer_data_present, buffer_half_full, buffer_full;
    logic       frame_error, overrun, parity_error;

    uart_rx_fifo #(.FIFO_AW(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .en_16_x_baud        (en_16_x_baud),
        .rx                  (rx),
        .buffer_read         (buffer_read),
        .buffer_reset        (buffer_reset),
        .data_out            (data_out),
        .buffer_data_present (buffer_data_present),
        .buffer_half_full    (buffer_half_full),
        .buffer_full         (buffer_full),
        .frame_error         (frame_error),
        .overrun             (overrun),
        .parity_error        (parity_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int div   = 1;
    int ph    = 0;

    // Baud tick: one clk in every div
    always begin
        @(posedge clk);
        #1;
        ph = (ph + 1 >= div) ? 0 : ph + 1;
        en_16_x_baud = (ph == 0);
    end

    // Reference model
    logic [7:0] q[$];
    int exp_fe = 0, exp_pe = 0, exp_ov = 0;

    // Pulse monitor
    int   fe_seen = 0, pe_seen = 0, ov_seen = 0, long_pulse = 0;
    logic fe_q = 1'b0, pe_q = 1'b0, ov_q = 1'b0;
    always @(negedge clk) begin
        fe_seen    += int'(frame_error);
        pe_seen    += int'(parity_error);
        ov_seen    += int'(overrun);
        long_pulse += int'(frame_error & fe_q) + int'(parity_error & pe_q)
                    + int'(overrun & ov_q);
        fe_q = frame_error;
        pe_q = parity_error;
        ov_q = overrun;
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] head();
        return (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    task automatic check_state(input string tag);
        @(negedge clk);
        check_val({tag, ".data_out"}, data_out, head());
        check_val({tag, ".present"},  buffer_data_present, q.size() != 0);
        check_val({tag, ".half"},     buffer_half_full, q.size() >= 8);
        check_val({tag, ".full"},     buffer_full, q.size() == 16);
        check_val({tag, ".fe_cnt"},   fe_seen, exp_fe);
        check_val({tag, ".pe_cnt"},   pe_seen, exp_pe);
        check_val({tag, ".ov_cnt"},   ov_seen, exp_ov);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, ".data_out"}, data_out, 8'h00);
        check_val({tag, ".present"},  buffer_data_present, 1'b0);
        check_val({tag, ".half"},     buffer_half_full, 1'b0);
        check_val({tag, ".full"},     buffer_full, 1'b0);
        check_val({tag, ".fe"},       frame_error, 1'b0);
        check_val({tag, ".ov"},       overrun, 1'b0);
        check_val({tag, ".pe"},       parity_error, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive one frame. rd_cyc / clr_cyc select the loop iteration in which
    // buffer_read / buffer_reset is asserted for one cycle (-1 = never).
    task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                              input bit par_flip, input int rd_cyc,
                              input int clr_cyc);
        logic [NB-1:0] bits;
        bits       = '0;
        bits[8:1]  = b;
`ifdef UART_RX_PARITY_EN
        bits[9]    = (^b) ^ par_flip;
`endif
        bits[NB-1] = stop_bit;
        for (int c = 0; c < NB * 16 * div; c++) begin
            @(posedge clk);
            #1;
            rx           = bits[c / (16 * div)];
            buffer_read  = (c == rd_cyc);
            buffer_reset = (c == clr_cyc);
            if (c == clr_cyc) q.delete();
            if (c == rd_cyc) begin
                @(negedge clk);
                check_val("rd_at_stop.data_out", data_out, head());
                if (q.size() != 0) void'(q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        rx           = 1'b1;
        buffer_read  = 1'b0;
        buffer_reset = 1'b0;
        if (!stop_bit)                exp_fe++;
        else if (PAR && par_flip)     exp_pe++;
        else if (q.size() == 16)      exp_ov++;
        else                          q.push_back(b);
        idle(8 + 2 * div);
    endtask

    task automatic read_one(input string tag);
        @(negedge clk);
        check_val(tag, data_out, head());
        @(posedge clk);
        #1 buffer_read = 1'b1;
        @(posedge clk);
        #1 buffer_read = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b1;
        idle(5);

        // Single byte and pop
        send_frame(8'h41, 1'b1, 1'b0, -1, -1);
        check_state("b41");
        read_one("b41.read");
        check_state("b41.empty");

        // Short low glitch on the line
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        idle(200);
        check_state("glitch");

        // Framing error, then recovery
        send_frame(8'h55, 1'b0, 1'b0, -1, -1);
        check_state("ferr");
        send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
        check_state("a5");
        read_one("a5.read");

        // Fill past capacity, then drain across pointer wrap
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, -1, -1);
            check_state($sformatf("fill%0d", i));
        end
        for (int i = 0; i < 16; i++) read_one($sformatf("drain%0d", i));
        check_state("drained");

        // Full FIFO with a read coincident with the stop sample
        for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, 1'b0, -1, -1);
        check_state("refill");
        send_frame(8'h3C, 1'b1, 1'b0, STOP_C, -1);
        check_state("full_rd_stop");
        while (q.size() != 0) read_one("drain_full");

        // FIFO clear while a frame is in flight
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1, 1'b0, -1, -1);
        send_frame(8'h9E, 1'b1, 1'b0, -1, 80);
        check_state("bufclr");
        read_one("bufclr.read");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, -1, -1);
        check_state("par_ok");
        send_frame(8'h07, 1'b1, 1'b1, -1, -1);
        check_state("par_bad");
        send_frame(8'h3A, 1'b0, 1'b1, -1, -1);
        check_state("par_and_ferr");
        read_one("par.read");
`endif

        // Randomised traffic at varying tick rates
        for (int r = 0; r < 30; r++) begin
            div = int'($urandom_range(1, 3));
            idle(4);
            send_frame(8'($urandom), ($urandom % 8) != 0, ($urandom % 8) == 0, -1, -1);
            check_state($sformatf("rnd%0d", r));
            for (int k = 0; k < int'($urandom % 3); k++) read_one("rnd.read");
        end
        div = 1;
        idle(4);
        while (q.size() != 0) read_one("rnd.drain");

        // Reset asserted in the middle of a frame
        send_frame(8'h11, 1'b1, 1'b0, -1, -1);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        reset = 1'b0;
        rx    = 1'b1;
        q.delete();
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        #1 reset = 1'b1;
        idle(20);
        check_state("post_rst.idle");
        send_frame(8'h5A, 1'b1, 1'b0, -1, -1);
        check_state("post_rst");
        read_one("post_rst.read");

        check_val("long_pulse", long_pulse, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receiver for the Bluetooth PMOD UART link, and the receive-side counterpart of the existing 16x-oversampled UART transmitter. It deserialises 8N1 frames on `rx` using the shared `en_16_x_baud` tick and pushes each good byte into an internal FIFO. The FIFO's handshake and status signals mirror the transmitter buffer, so the loopback path and the PicoBlaze input port can drain received bytes directly.

## Interface
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW words.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset).
- `en_16_x_baud`  input  1  one-`clk` tick at 16x baud; may be tied 1.
- `rx`  input  1  asynchronous serial line, idle high.
- `buffer_read`  input  1  pop the head word; ignored when the FIFO is empty.
- `buffer_reset`  input  1  synchronous FIFO clear; does not affect the receiver FSM.
- `data_out`  output  8  FIFO head word (first-word fall-through); 0x00 when empty.
- `buffer_data_present`  output  1  FIFO count > 0.
- `buffer_half_full`  output  1  count >= 2^(FIFO_AW-1).
- `buffer_full`  output  1  count == 2^FIFO_AW.
- `frame_error`  output  1  one-cycle pulse: stop bit sampled 0.
- `overrun`  output  1  one-cycle pulse: good byte dropped because the FIFO is full.
- `parity_error`  output  1  one-cycle pulse: parity mismatch; constant 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- **Input synchroniser:** `rx` passes through 2 flops, reset to 1, to give `rx_s`. All FSM decisions use `rx_s`.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **Tick counter:** 4 bits. It advances only on cycles where `en_16_x_baud` = 1.
- **IDLE:** moves to START on a 1->0 transition of `rx_s`; the tick counter clears to 0. A line held low (break) cannot start a second frame until it returns high.
- **START:** on the 8th tick (counter == 7), the receiver samples `rx_s`.
  - 0: go to DATA with counter = 0 and bit index = 0.
  - 1: treat as a glitch and return to IDLE.
- **DATA:** on every 16th tick (counter == 15), the receiver shifts `rx_s` into the shift register LSB-first.
  - After bit index 7, go to PARITY if enabled, otherwise to STOP.
- **STOP:** on the 16th tick, the receiver samples `rx_s` and returns to IDLE.
  - 1 and FIFO not full (or a read in the same cycle): write the byte.
  - 1 and FIFO full with no read in the same cycle: pulse `overrun` and drop the byte.
  - 0: pulse `frame_error`; nothing is written.
- **FIFO:** circular buffer with `FIFO_AW`-bit read/write pointers that wrap modulo depth, plus a `FIFO_AW+1`-bit count.
  - Read and write in the same cycle: both are performed and the count is unchanged. This also applies when full; the read frees the slot.
  - Read when empty: no effect.
  - `buffer_reset` = 1: pointers and count go to 0. If a write coincides with `buffer_reset`, the clear wins and the byte is lost.
- **Reset mid-frame:** FSM returns to IDLE, shift register and FIFO are cleared, and all pulses deassert.

## Timing
- **Reset values:** `data_out` = 0x00; `buffer_data_present`, `buffer_half_full`, `buffer_full`, `frame_error`, `overrun`, `parity_error` = 0; synchroniser flops = 1.
- **Sampling points:** counted in ticks after the falling edge is seen on `rx_s`.
  - Start bit: tick 8.
  - Data bit k (k = 0..7): tick 24 + 16k.
  - Stop bit: tick 152 without parity, 168 with parity.
- **FIFO write:** occurs on the stop-sample edge. `buffer_data_present` and `data_out` are valid from the following cycle.
- **Pulses:** `frame_error`, `overrun` and `parity_error` are registered and high for exactly one `clk` cycle after the sampling edge.
- **Read:** `buffer_read` takes effect on the same edge. `data_out` shows the next word in the following cycle.
- **Status flags:** registered, updated in the cycle after the count changes.
- **Input latency:** 2 `clk` cycles of synchroniser delay are added before edge detection.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - An even-parity bit follows the data; PARITY samples it on the 16th tick.
  - On mismatch, STOP still runs, the byte is discarded, and `parity_error` pulses at the stop sample. A frame error takes precedence: only `frame_error` pulses.
- **`UART_RX_PARITY_EN` undefined:** the PARITY state is absent, the frame is 8N1, and `parity_error` is tied to 0.

## Test plan
- **Single byte:** `en_16_x_baud` = 1, send 0x41 (8N1). `data_out` = 0x41 and `buffer_data_present` = 1 within 155 `clk` of the start edge; `buffer_read` pulse -> `buffer_data_present` = 0.
- **Glitch rejection:** drive `rx` low for 4 ticks, then high. No FSM exit from IDLE after tick 8, FIFO empty, no pulses.
- **Framing error:** send 0x55 with the stop bit at 0. `frame_error` is a single pulse, FIFO count stays 0, and the next valid 0xA5 is received correctly.
- **Full and overrun:** send 17 bytes 0x00..0x10 with no reads.
  - `buffer_half_full` rises after byte 8; `buffer_full` rises after byte 16.
  - Byte 0x10 raises `overrun`; reads return 0x00..0x0F in order with wrap-around.
- **Corner cases:**
  - Full FIFO with `buffer_read` coincident with the stop sample: count stays 16 and the new byte is stored.
  - `buffer_reset` mid-frame: FIFO empties and the in-flight byte still lands afterward.
  - `reset` low mid-frame: all outputs return to their reset values.
- **With `UART_RX_PARITY_EN`:** send 0x07 with parity 1 (correct, since 0x07 has three 1s) -> stored. Send with parity 0 -> `parity_error` pulse, nothing stored.
